// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter that puts NUM_CORES cores onto one single-port DRAM.
// It runs one transaction at a time and every output comes straight from a flop.
// rr_ptr holds the most recently served core. That core gets the lowest priority at the next grant.
module dram_port_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CORES-1:0]        i_core_req,
  input  logic [NUM_CORES-1:0]        i_core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_wdata,
  output logic [NUM_CORES-1:0]        o_core_done,
  output logic [DATA_W-1:0]           o_core_rdata,
  output logic                        o_busy,
  output logic                        o_mem_write_en,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_data_in,
  input  logic [DATA_W-1:0]           i_mem_data_out
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic                   r_mem_write_en;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_data_in;
  logic [DATA_W-1:0]      r_core_rdata;
  logic [NUM_CORES-1:0]   r_core_done;
  logic                   r_busy;

  state_t                 w_state_nxt;
  logic [PTR_W-1:0]       w_rr_nxt;
  logic                   w_we_nxt;
  logic [ADDR_W-1:0]      w_addr_nxt;
  logic [DATA_W-1:0]      w_wdata_nxt;
  logic [DATA_W-1:0]      w_rdata_nxt;
  logic [NUM_CORES-1:0]   w_done_nxt;
  logic                   w_busy_nxt;

  logic                   w_found;
  logic [PTR_W-1:0]       w_idx;
  logic [PTR_W-1:0]       w_winner;
  logic                   w_sel_we;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic [NUM_CORES-1:0]   w_grant_onehot;

  // Find the first requesting core, scanning upward from the core after rr_ptr and wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + k) % NUM_CORES);
      if (!w_found && i_core_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Select the winning core's command fields from the packed buses.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_winner == PTR_W'(i)) begin
        w_sel_we    = i_core_we[i];
        w_sel_addr  = i_core_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = i_core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_grant_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << r_rr_ptr;

  // Next-state and next-output logic. Every register keeps its value unless a state below changes it.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_we_nxt    = r_mem_write_en;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_data_in;
    w_rdata_nxt = r_core_rdata;
    w_done_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_ISSUE;
          w_rr_nxt    = w_winner;
          w_we_nxt    = w_sel_we;
          w_addr_nxt  = w_sel_addr;
          w_wdata_nxt = w_sel_wdata;
        end
      end
      S_ISSUE: begin
        // The DRAM acts at the end of this cycle.
        // Writes are finished here. Reads wait one more cycle for the registered data.
        w_we_nxt = 1'b0;
        if (r_mem_write_en) begin
          w_done_nxt  = w_grant_onehot;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_rdata_nxt = i_mem_data_out;
        w_done_nxt  = w_grant_onehot;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Requests are ignored here, so the core that just finished can drop its request safely.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers. An async reset drops the write enable at once and discards any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= PTR_W'(NUM_CORES - 1);
      r_mem_write_en <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data_in  <= '0;
      r_core_rdata   <= '0;
      r_core_done    <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rr_ptr       <= w_rr_nxt;
      r_mem_write_en <= w_we_nxt;
      r_mem_addr     <= w_addr_nxt;
      r_mem_data_in  <= w_wdata_nxt;
      r_core_rdata   <= w_rdata_nxt;
      r_core_done    <= w_done_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  assign o_core_done    = r_core_done;
  assign o_core_rdata   = r_core_rdata;
  assign o_busy         = r_busy;
  assign o_mem_write_en = r_mem_write_en;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_data_in  = r_mem_data_in;

endmodule
